// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
// Holds the default trigger/event FIFO geometry, the occupancy type for that
// geometry and a ceiling-log2 helper for sizing derived counters.
package fifo_pkg;

  localparam int DEF_W  = 33;
  localparam int DEF_AW = 11;

  // Occupancy count for the default geometry: one bit wider than the address
  // so a completely full FIFO does not read back as zero.
  typedef logic [DEF_AW:0] occ_t;

  function automatic int clog2(input int value);
    int result = 0;
    int v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM for the FIFO storage array.
// One write port and one registered read port, both on clk. The contents are
// never reset. A read and a write to the same address in one cycle return the
// old word.
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(2**AW)-1];

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_gen.sv
// Parametrised single-clock FIFO for trigger-data and event words.
// Tracks an exact occupancy count, full/empty decodes, registered threshold
// flags, sticky overflow/underflow errors and the peak occupancy.
// Define FIFO_FWFT_EN to build the first-word fall-through variant, in which
// the RAM read register acts as an output stage that always holds the head word.
module fifo_sync_gen
  import fifo_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int AW        = DEF_AW,
  parameter int AFULL_TH  = 1792,
  parameter int AEMPTY_TH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic          wen,
  input  logic          ren,
  input  logic          clr_err,
  output logic [W-1:0]  q,
  output logic          nempty,
  output logic          full,
  output logic [AW:0]   nwords,
  output logic          nearlyfull,
  output logic          nearlyempty,
  output logic          overflow,
  output logic          underflow,
  output logic [AW:0]   maxwords
);

  localparam logic [AW:0] DEPTH_CNT  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_CNT  = AFULL_TH[AW:0];
  localparam logic [AW:0] AEMPTY_CNT = AEMPTY_TH[AW:0];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [AW:0]   peak_next;
  logic          rd_ok;
  logic          wr_ok;
  logic          ovf_evt;
  logic          unf_evt;
  logic          ram_re;
  logic [W-1:0]  ram_q;

  assign nwords  = count;
  assign full    = (count == DEPTH_CNT);
  assign rd_ok   = ren && nempty;
  assign wr_ok   = wen && (!full || rd_ok);
  assign ovf_evt = wen && !wr_ok;
  assign unf_evt = ren && !nempty;

`ifdef FIFO_FWFT_EN
  logic        head_valid;
  logic        load;
  logic [AW:0] ram_count;
  logic [AW:0] ram_count_next;

  assign nempty = head_valid;
  assign load   = (ram_count != '0) && (!head_valid || rd_ok);
  assign ram_re = load;
  assign q      = head_valid ? ram_q : '0;

  // Words still waiting in the RAM behind the output stage.
  always_comb begin
    ram_count_next = ram_count;
    if (wr_ok && !load) begin
      ram_count_next = ram_count + (AW+1)'(1);
    end else if (load && !wr_ok) begin
      ram_count_next = ram_count - (AW+1)'(1);
    end
  end

  // Output stage: refill from the RAM whenever it is empty or being popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid <= 1'b0;
      ram_count  <= '0;
    end else begin
      ram_count <= ram_count_next;
      if (load) begin
        head_valid <= 1'b1;
      end else if (rd_ok) begin
        head_valid <= 1'b0;
      end
    end
  end
`else
  logic q_zero;

  assign nempty = (count != '0);
  assign ram_re = rd_ok;
  assign q      = q_zero ? '0 : ram_q;

  // Force q to zero after reset or a rejected read until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_zero <= 1'b1;
    end else if (rd_ok) begin
      q_zero <= 1'b0;
    end else if (unf_evt) begin
      q_zero <= 1'b1;
    end
  end
`endif

  // Next occupancy and next peak value; a simultaneous read and write cancel.
  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok) begin
      count_next = count + (AW+1)'(1);
    end else if (rd_ok && !wr_ok) begin
      count_next = count - (AW+1)'(1);
    end
    if (clr_err) begin
      peak_next = count_next;
    end else begin
      peak_next = (count_next > maxwords) ? count_next : maxwords;
    end
  end

  // Write and read pointers wrap naturally modulo the depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (ram_re) begin
        rptr <= rptr + AW'(1);
      end
    end
  end

  // Occupancy, threshold flags, sticky errors and peak tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      nearlyfull  <= 1'b0;
      nearlyempty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      maxwords    <= '0;
    end else begin
      count       <= count_next;
      nearlyfull  <= (count_next >= AFULL_CNT);
      nearlyempty <= (count_next <= AEMPTY_CNT);
      overflow    <= ovf_evt || (overflow && !clr_err);
      underflow   <= unf_evt || (underflow && !clr_err);
      maxwords    <= peak_next;
    end
  end

  fifo_ram_dp #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (d),
    .re    (ram_re),
    .raddr (rptr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_fifo_sync_gen.sv
// Self-checking bench for fifo_sync_gen (DEPTH=16, AFULL_TH=12, AEMPTY_TH=2).
// Honours FIFO_FWFT_EN to exercise the first-word fall-through build.
module tb_fifo_sync_gen;

  localparam int W         = 33;
  localparam int AW        = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d;
  logic          wen;
  logic          ren;
  logic          clr_err;
  logic [W-1:0]  q;
  logic          nempty;
  logic          full;
  logic [AW:0]   nwords;
  logic          nearlyfull;
  logic          nearlyempty;
  logic          overflow;
  logic          underflow;
  logic [AW:0]   maxwords;

  int n_checks = 0;
  int n_fail   = 0;

  int           m_cnt;
  int           m_max;
  bit           m_ovf;
  bit           m_unf;
  logic [W-1:0] m_q;
  logic [W-1:0] sb [$];

  typedef struct {
    logic wen;
    logic ren;
    int   exp_nwords;
    logic exp_nf;
    logic exp_ne;
    int   exp_max;
  } vec_t;

  vec_t tbl [23];

  fifo_sync_gen #(
    .W         (W),
    .AW        (AW),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .wen         (wen),
    .ren         (ren),
    .clr_err     (clr_err),
    .q           (q),
    .nempty      (nempty),
    .full        (full),
    .nwords      (nwords),
    .nearlyfull  (nearlyfull),
    .nearlyempty (nearlyempty),
    .overflow    (overflow),
    .underflow   (underflow),
    .maxwords    (maxwords)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: still running at %0t, limit 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOne(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_cnt = 0;
    m_max = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_q   = '0;
    sb.delete();
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [W-1:0] data);
    bit rd;
    bit wr;
    wen     = w;
    ren     = r;
    clr_err = c;
    d       = data;
    rd = r && (m_cnt > 0);
    wr = w && ((m_cnt < DEPTH) || rd);
    @(posedge clk);
    #1;
    wen     = 1'b0;
    ren     = 1'b0;
    clr_err = 1'b0;
    if (rd) begin
      m_q = sb.pop_front();
    end else if (r) begin
      m_q = '0;
    end
    if (wr) begin
      sb.push_back(data);
    end
    m_cnt = m_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    m_ovf = (w && !wr) || (m_ovf && !c);
    m_unf = (r && !rd) || (m_unf && !c);
    m_max = c ? m_cnt : ((m_cnt > m_max) ? m_cnt : m_max);
  endtask

  task automatic checkResetValues(input string tag);
    checkOne({tag, "_nwords"},      64'(nwords),      64'(0));
    checkOne({tag, "_full"},        64'(full),        64'(0));
    checkOne({tag, "_nempty"},      64'(nempty),      64'(0));
    checkOne({tag, "_q"},           64'(q),           64'(0));
    checkOne({tag, "_nearlyfull"},  64'(nearlyfull),  64'(0));
    checkOne({tag, "_nearlyempty"}, 64'(nearlyempty), 64'(1));
    checkOne({tag, "_overflow"},    64'(overflow),    64'(0));
    checkOne({tag, "_underflow"},   64'(underflow),   64'(0));
    checkOne({tag, "_maxwords"},    64'(maxwords),    64'(0));
  endtask

`ifndef FIFO_FWFT_EN
  task automatic checkOutput();
    checkOne("nwords",      64'(nwords),      64'(m_cnt));
    checkOne("full",        64'(full),        64'(m_cnt == DEPTH));
    checkOne("nempty",      64'(nempty),      64'(m_cnt != 0));
    checkOne("nearlyfull",  64'(nearlyfull),  64'(m_cnt >= AFULL_TH));
    checkOne("nearlyempty", 64'(nearlyempty), 64'(m_cnt <= AEMPTY_TH));
    checkOne("overflow",    64'(overflow),    64'(m_ovf));
    checkOne("underflow",   64'(underflow),   64'(m_unf));
    checkOne("maxwords",    64'(maxwords),    64'(m_max));
    checkOne("q",           64'(q),           64'(m_q));
  endtask
`endif

  initial begin
    logic [W-1:0] base;
    base = 33'h1_0000_0000;

    for (int i = 0; i < 12; i++) begin
      tbl[i] = '{1'b1, 1'b0, i + 1, (i + 1) >= 12, (i + 1) <= 2, i + 1};
    end
    for (int j = 0; j < 11; j++) begin
      tbl[12 + j] = '{1'b0, 1'b1, 11 - j, 1'b0, (11 - j) <= 2, 12};
    end

    rst     = 1'b1;
    wen     = 1'b0;
    ren     = 1'b0;
    clr_err = 1'b0;
    d       = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifndef FIFO_FWFT_EN
    $display("[TB] fill and drain, overflow, read/write at full");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, base + W'(i));
      checkOutput();
    end
    checkOne("full_at_16", 64'(full), 64'(1));

    applyStimulus(1'b1, 1'b0, 1'b0, 33'h0_BAD0_BAD0);
    checkOutput();
    checkOne("ovf_set", 64'(overflow), 64'(1));
    checkOne("ovf_nwords", 64'(nwords), 64'(16));
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput();
    checkOne("ovf_cleared", 64'(overflow), 64'(0));

    applyStimulus(1'b1, 1'b1, 1'b0, 33'h1_ABCD_0000);
    checkOutput();
    checkOne("rw_full_nwords", 64'(nwords), 64'(16));
    checkOne("rw_full_first", 64'(q), 64'(base));
    checkOne("rw_full_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput();
    end
    checkOne("rw_full_last_word", 64'(q), 64'(33'h1_ABCD_0000));
    checkOne("drain_nwords", 64'(nwords), 64'(0));
    checkOne("drain_nempty", 64'(nempty), 64'(0));

    $display("[TB] underflow");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput();
    checkOne("unf_q", 64'(q), 64'(0));
    checkOne("unf_flag", 64'(underflow), 64'(1));
    checkOne("unf_nwords", 64'(nwords), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput();
    checkOne("unf_cleared", 64'(underflow), 64'(0));

    $display("[TB] thresholds and peak table");
    for (int i = 0; i < 23; i++) begin
      applyStimulus(tbl[i].wen, tbl[i].ren, 1'b0, 33'h0_5000_0000 + W'(i));
      checkOutput();
      checkOne($sformatf("tbl%0d_nwords", i), 64'(nwords), 64'(tbl[i].exp_nwords));
      checkOne($sformatf("tbl%0d_nf", i), 64'(nearlyfull), 64'(tbl[i].exp_nf));
      checkOne($sformatf("tbl%0d_ne", i), 64'(nearlyempty), 64'(tbl[i].exp_ne));
      checkOne($sformatf("tbl%0d_max", i), 64'(maxwords), 64'(tbl[i].exp_max));
    end
`endif

    $display("[TB] asynchronous reset with words stored");
    while (m_cnt < 5) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 33'h0_7700_0000 + W'(m_cnt));
    end
    checkOne("pre_rst_nwords", 64'(nwords), 64'(5));
    #2;
    rst = 1'b1;
    wen = 1'b1;
    ren = 1'b1;
    d   = 33'h1_1111_1111;
    #1;
    checkResetValues("async_rst");
    @(posedge clk);
    #1;
    checkOne("rst_held_nwords", 64'(nwords), 64'(0));
    checkOne("rst_held_ovf", 64'(overflow), 64'(0));
    wen = 1'b0;
    ren = 1'b0;
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

`ifdef FIFO_FWFT_EN
    $display("[TB] first-word fall-through");
    wen = 1'b1;
    d   = 33'h0_DEAD_BEEF;
    @(posedge clk);
    #1;
    wen = 1'b0;
    checkOne("fwft_edge1_nempty", 64'(nempty), 64'(0));
    checkOne("fwft_edge1_nwords", 64'(nwords), 64'(1));
    @(posedge clk);
    #1;
    checkOne("fwft_edge2_nempty", 64'(nempty), 64'(1));
    checkOne("fwft_edge2_q", 64'(q), 64'(33'h0_DEAD_BEEF));
    ren = 1'b1;
    @(posedge clk);
    #1;
    checkOne("fwft_pop_nempty", 64'(nempty), 64'(0));
    checkOne("fwft_pop_nwords", 64'(nwords), 64'(0));
    @(posedge clk);
    #1;
    ren = 1'b0;
    checkOne("fwft_unf_flag", 64'(underflow), 64'(1));
    checkOne("fwft_unf_q", 64'(q), 64'(0));
`else
    $display("[TB] operation after reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 33'h0_0C0F_FEE0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput();
    checkOne("post_rst_q", 64'(q), 64'(33'h0_0C0F_FEE0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
